jtpopeye_dma: RTL and testbench

Bus-master side of the main-board sprite DMA. On each vertical blank it requests the main Z80 bus (`busrq_n`), waits for grant (`busak_n`), streams `LEN` bytes out of the main work RAM upper half (RAM address `{1'b1, AD_DMA}`) through the `dma_cs`/`AD_DMA`/`DD_DMA` port, writes them into the video-side object buffer, then releases the bus. It sits on the video board between the main CPU module and the object line engine.

---
 rtl/jtpopeye_dma_pkg.sv | 15 +
 rtl/jtpopeye_dma.sv | 125 ++++++++++++
 tb/tb_jtpopeye_dma.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtpopeye_dma_pkg.sv
// Shared constants for the Popeye sprite DMA: FSM encoding and default frame geometry.
// The object line engine imports the same package so both sides agree on the frame length.
package jtpopeye_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_REL  = 2'd3
  } dma_state_e;

  localparam logic [9:0] DEF_LEN  = 10'd640;
  localparam logic [9:0] DEF_BASE = 10'd0;

endpackage

// File: rtl/jtpopeye_dma.sv
// Sprite DMA bus master: on each VB rising edge, borrows the main Z80 bus and copies
// LEN bytes from work RAM {1'b1, AD_DMA} into the video-side object buffer.
module jtpopeye_dma
  import jtpopeye_dma_pkg::*;
#(
  parameter logic [9:0] LEN  = DEF_LEN,
  parameter logic [9:0] BASE = DEF_BASE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_cen,
  input  logic       VB,
  output logic       busrq_n,
  input  logic       busak_n,
  output logic       dma_cs,
  output logic [9:0] AD_DMA,
  input  logic [7:0] DD_DMA,
  output logic [9:0] obj_addr,
  output logic [7:0] obj_data,
  output logic       obj_we,
  output logic       busy,
  output logic       overrun
);

  dma_state_e r_state;
  logic       r_vbl;
  logic [9:0] r_issued;
  logic [9:0] r_captured;
  logic       r_p1_valid;
  logic       r_p2_valid;
  logic [9:0] r_p1_addr;
  logic [9:0] r_p2_addr;
  logic       w_trigger;

  assign w_trigger = VB & ~r_vbl;

  // NOTE: every register here is reset asynchronously and assigned with <= so all
  // updates in one cpu_cen step see the previous values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_vbl      <= 1'b0;
      r_issued   <= '0;
      r_captured <= '0;
      r_p1_valid <= 1'b0;
      r_p2_valid <= 1'b0;
      r_p1_addr  <= '0;
      r_p2_addr  <= '0;
      busrq_n    <= 1'b1;
      dma_cs     <= 1'b0;
      AD_DMA     <= BASE;
      obj_addr   <= '0;
      obj_data   <= '0;
      obj_we     <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else if (cpu_cen) begin
      r_vbl <= VB;
      if (w_trigger && r_state != ST_IDLE) overrun <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            r_state <= ST_REQ;
            busrq_n <= 1'b0;
            busy    <= 1'b1;
          end
        end

        ST_REQ: begin
          // The grant edge issues the first address, so it enters the read pipe here.
          if (!busak_n) begin
            r_state    <= ST_XFER;
            dma_cs     <= 1'b1;
            AD_DMA     <= BASE;
            r_issued   <= 10'd1;
            r_captured <= '0;
            r_p1_valid <= 1'b1;
            r_p1_addr  <= '0;
            r_p2_valid <= 1'b0;
          end
        end

        ST_XFER: begin
          if (busak_n || r_captured == LEN) begin
            // Bus taken back early or frame complete: drop whatever is still in flight.
            r_state    <= ST_REL;
            busrq_n    <= 1'b1;
            dma_cs     <= 1'b0;
            obj_we     <= 1'b0;
            r_p1_valid <= 1'b0;
            r_p2_valid <= 1'b0;
          end else begin
            r_p2_valid <= r_p1_valid;
            r_p2_addr  <= r_p1_addr;
            if (r_issued < LEN) begin
              AD_DMA     <= AD_DMA + 10'd1;
              r_p1_valid <= 1'b1;
              r_p1_addr  <= r_issued;
              r_issued   <= r_issued + 10'd1;
            end else begin
              r_p1_valid <= 1'b0;
            end
            obj_we <= r_p2_valid;
            if (r_p2_valid) begin
              obj_data   <= DD_DMA;
              obj_addr   <= r_p2_addr;
              r_captured <= r_captured + 10'd1;
            end
          end
        end

        ST_REL: begin
          if (busak_n) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtpopeye_dma.sv
// Self-checking bench for jtpopeye_dma: two instances (default geometry and a wrapping
// BASE=900/LEN=200 one), registered RAM models and a scoreboard of expected buffer writes.
module tb_jtpopeye_dma;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;

  logic       vb = 1'b0, busak_n = 1'b1, busrq_n, dma_cs, obj_we, busy, overrun;
  logic [9:0] ad, obj_addr;
  logic [7:0] dd = 8'h00, obj_data;

  logic       vb2 = 1'b0, busak2_n = 1'b1, busrq2_n, dma_cs2, obj_we2, busy2, overrun2;
  logic [9:0] ad2, obj_addr2;
  logic [7:0] dd2 = 8'h00, obj_data2;

  logic [17:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  jtpopeye_dma dut (
    .clk(clk), .rst_n(rst_n), .cpu_cen(cen), .VB(vb), .busrq_n(busrq_n), .busak_n(busak_n),
    .dma_cs(dma_cs), .AD_DMA(ad), .DD_DMA(dd), .obj_addr(obj_addr), .obj_data(obj_data),
    .obj_we(obj_we), .busy(busy), .overrun(overrun)
  );

  jtpopeye_dma #(.LEN(10'd200), .BASE(10'd900)) dut2 (
    .clk(clk), .rst_n(rst_n), .cpu_cen(cen), .VB(vb2), .busrq_n(busrq2_n), .busak_n(busak2_n),
    .dma_cs(dma_cs2), .AD_DMA(ad2), .DD_DMA(dd2), .obj_addr(obj_addr2), .obj_data(obj_data2),
    .obj_we(obj_we2), .busy(busy2), .overrun(overrun2)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    cen = ~cen;
  end

  function automatic logic [7:0] ram_byte(input logic [9:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Work RAM upper half, one cen of read latency.
  always @(posedge clk) begin
    if (cen) begin
      dd  <= ram_byte(ad);
      dd2 <= ram_byte(ad2);
    end
  end

  task automatic tick();
    do @(posedge clk); while (cen !== 1'b1);
    #1;
  endtask

  task automatic do_reset();
    vb = 1'b0; vb2 = 1'b0; busak_n = 1'b1; busak2_n = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({busrq_n, dma_cs, ad, obj_addr, obj_data, obj_we, busy, overrun} !==
        {1'b1, 1'b0, 10'd0, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state got rq=%b cs=%b ad=%0d oa=%0d od=%02h we=%b busy=%b ovr=%b want 1 0 0 0 00 0 0 0",
               busrq_n, dma_cs, ad, obj_addr, obj_data, obj_we, busy, overrun);
    end
    n_cmp++;
    if ({busrq2_n, dma_cs2, ad2, obj_we2, busy2} !== {1'b1, 1'b0, 10'd900, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state2 got rq=%b cs=%b ad=%0d we=%b busy=%b want 1 0 900 0 0",
               busrq2_n, dma_cs2, ad2, obj_we2, busy2);
    end
  endtask

  // Full 640-byte frame; optionally re-raises VB during XFER to provoke overrun.
  task automatic test_full(input bit with_overrun);
    int n_wr = 0, t_cs = -1, t_first = -1, last_wr = -1, cs_ticks = 0, t;
    logic [17:0] e;
    exp_q.delete();
    for (int i = 0; i < 640; i++) exp_q.push_back({10'(i), ram_byte(10'(i))});
    vb = 1'b1;
    tick();
    n_cmp++;
    if ({busrq_n, busy, dma_cs} !== 3'b010) begin
      n_err++; $display("FAIL request_latency got rq/busy/cs=%b want 010", {busrq_n, busy, dma_cs});
    end
    vb = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({busrq_n, dma_cs} !== 2'b00) begin
      n_err++; $display("FAIL wait_grant got rq/cs=%b want 00", {busrq_n, dma_cs});
    end
    busak_n = 1'b0;
    for (t = 0; t < 2000 && !(cs_ticks > 0 && !dma_cs); t++) begin
      tick();
      if (dma_cs) begin
        cs_ticks++;
        if (t_cs < 0) t_cs = t;
      end
      if (obj_we) begin
        n_cmp++;
        if (!dma_cs) begin n_err++; $display("FAIL we_outside_xfer got we=1 cs=0 want cs=1"); end
        if (t_first < 0) t_first = t;
        if (last_wr >= 0) begin
          n_cmp++;
          if (t != last_wr + 1) begin n_err++; $display("FAIL back_to_back got gap=%0d want 1", t - last_wr); end
        end
        last_wr = t;
        n_wr++;
        if (with_overrun && n_wr == 10) vb = 1'b1;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL full_extra_write got addr=%0d want none", obj_addr);
        end else begin
          e = exp_q.pop_front();
          if ({obj_addr, obj_data} !== e) begin
            n_err++;
            $display("FAIL full_write got addr=%0d data=%02h want addr=%0d data=%02h",
                     obj_addr, obj_data, e[17:8], e[7:0]);
          end
        end
      end
    end
    n_cmp++;
    if (t_cs !== 0) begin n_err++; $display("FAIL grant_to_cs got %0d cens want 0 after grant sample", t_cs); end
    n_cmp++;
    if (t_first - t_cs !== 2) begin n_err++; $display("FAIL first_write_delay got %0d want 2", t_first - t_cs); end
    n_cmp++;
    if (n_wr !== 640 || exp_q.size() != 0) begin
      n_err++; $display("FAIL write_count got %0d left=%0d want 640 left=0", n_wr, exp_q.size());
    end
    n_cmp++;
    if (cs_ticks !== 642) begin n_err++; $display("FAIL xfer_length got %0d want 642", cs_ticks); end
    n_cmp++;
    if ({busrq_n, busy, overrun} !== {1'b1, 1'b1, with_overrun}) begin
      n_err++; $display("FAIL release got rq/busy/ovr=%b want 11%b", {busrq_n, busy, overrun}, with_overrun);
    end
    busak_n = 1'b1;
    tick();
    n_cmp++;
    if ({busy, busrq_n} !== 2'b01) begin
      n_err++; $display("FAIL back_to_idle got busy/rq=%b want 01", {busy, busrq_n});
    end
  endtask

  // VB still high after the overrun: no new request until a fresh rising edge.
  task automatic test_overrun();
    int n_low = 0;
    test_full(1'b1);
    repeat (5) begin
      tick();
      if (busrq_n !== 1'b1) n_low++;
    end
    n_cmp++;
    if (n_low != 0) begin n_err++; $display("FAIL no_second_request got %0d low cens want 0", n_low); end
    vb = 1'b0;
    tick();
    vb = 1'b1;
    tick();
    n_cmp++;
    if (busrq_n !== 1'b0) begin n_err++; $display("FAIL new_edge_request got rq=%b want 0", busrq_n); end
  endtask

  task automatic test_trigger_with_grant();
    do_reset();
    busak_n = 1'b0;
    vb = 1'b1;
    tick();
    n_cmp++;
    if ({busrq_n, dma_cs} !== 2'b00) begin
      n_err++; $display("FAIL trig_grant_same got rq/cs=%b want 00", {busrq_n, dma_cs});
    end
    vb = 1'b0;
    tick();
    n_cmp++;
    if (dma_cs !== 1'b1) begin n_err++; $display("FAIL trig_grant_next got cs=%b want 1", dma_cs); end
    tick();
    busak_n = 1'b1;
    tick();
    n_cmp++;
    if ({busrq_n, dma_cs, obj_we, busy} !== 4'b1001) begin
      n_err++; $display("FAIL early_abort got rq/cs/we/busy=%b want 1001", {busrq_n, dma_cs, obj_we, busy});
    end
  endtask

  task automatic test_reset_mid_xfer();
    int n_wr = 0, n_after = 0;
    logic [17:0] e;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 640; i++) exp_q.push_back({10'(i), ram_byte(10'(i))});
    vb = 1'b1;
    tick();
    vb = 1'b0;
    busak_n = 1'b0;
    for (int t = 0; t < 1000 && n_wr < 100; t++) begin
      tick();
      if (obj_we) begin
        n_wr++;
        e = exp_q.pop_front();
        n_cmp++;
        if ({obj_addr, obj_data} !== e) begin
          n_err++;
          $display("FAIL rst_xfer_write got addr=%0d data=%02h want addr=%0d data=%02h",
                   obj_addr, obj_data, e[17:8], e[7:0]);
        end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busrq_n, dma_cs, obj_we, busy, ad} !== {4'b1000, 10'd0}) begin
      n_err++;
      $display("FAIL async_reset got rq/cs/we/busy=%b ad=%0d want 1000 ad=0", {busrq_n, dma_cs, obj_we, busy}, ad);
    end
    busak_n = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    exp_q.delete();
    repeat (20) begin
      tick();
      if (obj_we || !busrq_n) n_after++;
    end
    n_cmp++;
    if (n_after != 0 || n_wr != 100) begin
      n_err++; $display("FAIL no_writes_after_reset got %0d active cens, %0d writes want 0, 100", n_after, n_wr);
    end
  endtask

  task automatic test_abort();
    int n_wr = 0;
    logic [17:0] e;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 640; i++) exp_q.push_back({10'(i), ram_byte(10'(i))});
    vb = 1'b1;
    tick();
    vb = 1'b0;
    busak_n = 1'b0;
    for (int t = 0; t < 1000 && n_wr < 50; t++) begin
      tick();
      if (obj_we) begin
        n_wr++;
        e = exp_q.pop_front();
        n_cmp++;
        if ({obj_addr, obj_data} !== e) begin
          n_err++;
          $display("FAIL abort_write got addr=%0d data=%02h want addr=%0d data=%02h",
                   obj_addr, obj_data, e[17:8], e[7:0]);
        end
      end
    end
    busak_n = 1'b1;
    tick();
    n_cmp++;
    if ({busrq_n, dma_cs, obj_we} !== 3'b100) begin
      n_err++; $display("FAIL abort_release got rq/cs/we=%b want 100", {busrq_n, dma_cs, obj_we});
    end
    repeat (10) begin
      tick();
      if (obj_we) n_wr++;
    end
    n_cmp++;
    if (n_wr != 50 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_count got writes=%0d busy=%b want 50 0", n_wr, busy);
    end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    int n_wr = 0, n_iss = 0, cs_seen = 0;
    logic [17:0] e;
    exp_q.delete();
    for (int i = 0; i < 200; i++) exp_q.push_back({10'(i), ram_byte(10'(900 + i))});
    vb2 = 1'b1;
    tick();
    vb2 = 1'b0;
    busak2_n = 1'b0;
    for (int t = 0; t < 1000 && !(cs_seen > 0 && !dma_cs2); t++) begin
      tick();
      if (dma_cs2) begin
        cs_seen++;
        if (n_iss < 200) begin
          n_cmp++;
          if (ad2 !== 10'(900 + n_iss)) begin
            n_err++; $display("FAIL wrap_addr got %0d want %0d", ad2, 10'(900 + n_iss));
          end
          n_iss++;
        end
      end
      if (obj_we2) begin
        n_wr++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL wrap_extra_write got addr=%0d want none", obj_addr2);
        end else begin
          e = exp_q.pop_front();
          if ({obj_addr2, obj_data2} !== e) begin
            n_err++;
            $display("FAIL wrap_write got addr=%0d data=%02h want addr=%0d data=%02h",
                     obj_addr2, obj_data2, e[17:8], e[7:0]);
          end
        end
      end
    end
    n_cmp++;
    if (n_wr != 200 || n_iss != 200) begin
      n_err++; $display("FAIL wrap_count got writes=%0d issued=%0d want 200 200", n_wr, n_iss);
    end
    busak2_n = 1'b1;
    tick();
    n_cmp++;
    if ({busy2, busrq2_n} !== 2'b01) begin
      n_err++; $display("FAIL wrap_idle got busy/rq=%b want 01", {busy2, busrq2_n});
    end
  endtask

  initial begin
    test_reset();
    test_full(1'b0);
    test_overrun();
    test_trigger_with_grant();
    test_reset_mid_xfer();
    test_abort();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "bench timeout");
  end

endmodule
